// File: rtl/csm_arbiter.sv
// Two-port shared-memory controller: round-robin arbitration between A and B,
// per-location hold ownership, one-cycle registered responses and error count.
module csm_arbiter #(
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                a_req_valid,
    output logic                a_req_ready,
    input  logic [1:0]          a_op,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic                a_rsp_valid,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_err,
    input  logic                b_req_valid,
    output logic                b_req_ready,
    input  logic [1:0]          b_op,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic                b_rsp_valid,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int NUM_LOC = 2**ADDR_W;

    typedef enum logic [1:0] {
        OWN_FREE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_HOLD    = 2'd2,
        OP_RELEASE = 2'd3
    } op_t;

    logic [DATA_W-1:0]   mem_q [NUM_LOC];
    owner_t              owner_q [NUM_LOC];
    logic                rr_b_q, rr_b_d;
    logic                a_rsp_valid_q, b_rsp_valid_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
    logic                a_err_q, b_err_q;
    logic [ERRCNT_W-1:0] err_count_q;

    logic                gnt_a, gnt_b, gnt_any;
    op_t                 op_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   wdata_s;
    owner_t              req_own, cur_own, own_d;
    logic                is_other, err_d, mem_we, own_we;
    logic [DATA_W-1:0]   rdata_d;

    // rr_b_q selects which side wins a contended cycle; single requesters always win.
    always_comb begin
        gnt_a   = reset_n && a_req_valid && (!b_req_valid || !rr_b_q);
        gnt_b   = reset_n && b_req_valid && (!a_req_valid || rr_b_q);
        gnt_any = gnt_a || gnt_b;
        rr_b_d  = (a_req_valid && b_req_valid) ? !rr_b_q : rr_b_q;

        op_s    = op_t'(gnt_b ? b_op : a_op);
        addr_s  = gnt_b ? b_addr : a_addr;
        wdata_s = gnt_b ? b_wdata : a_wdata;
        req_own = gnt_b ? OWN_B : OWN_A;
        cur_own = owner_q[addr_s];
        is_other = (cur_own != OWN_FREE) && (cur_own != req_own);

        err_d   = 1'b0;
        rdata_d = '0;
        mem_we  = 1'b0;
        own_we  = 1'b0;
        own_d   = cur_own;

        unique case (op_s)
            OP_READ: begin
                if (is_other) err_d = 1'b1;
                else          rdata_d = mem_q[addr_s];
            end
            OP_WRITE: begin
                if (is_other) err_d = 1'b1;
                else          mem_we = 1'b1;
            end
            OP_HOLD: begin
                if (is_other) err_d = 1'b1;
                else if (cur_own == OWN_FREE) begin
                    own_we = 1'b1;
                    own_d  = req_own;
                end
            end
            OP_RELEASE: begin
                if (cur_own == req_own) begin
                    own_we = 1'b1;
                    own_d  = OWN_FREE;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: err_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q         <= '{default: '0};
            owner_q       <= '{default: OWN_FREE};
            rr_b_q        <= 1'b0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            a_rdata_q     <= '0;
            b_rdata_q     <= '0;
            a_err_q       <= 1'b0;
            b_err_q       <= 1'b0;
            err_count_q   <= '0;
        end else begin
            if (gnt_any && mem_we) mem_q[addr_s] <= wdata_s;
            if (gnt_any && own_we) owner_q[addr_s] <= own_d;
            rr_b_q        <= rr_b_d;
            a_rsp_valid_q <= gnt_a;
            b_rsp_valid_q <= gnt_b;
            a_rdata_q     <= gnt_a ? rdata_d : '0;
            b_rdata_q     <= gnt_b ? rdata_d : '0;
            a_err_q       <= gnt_a && err_d;
            b_err_q       <= gnt_b && err_d;
            if (gnt_any && err_d && (err_count_q != '1))
                err_count_q <= err_count_q + ERRCNT_W'(1);
        end
    end

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;
    assign a_rsp_valid = a_rsp_valid_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign a_err       = a_err_q;
    assign b_err       = b_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_csm_arbiter.sv
// Bench for csm_arbiter: directed plan steps plus a randomized phase, all
// checked against an array-based model of memory, ownership and arbitration.
module tb_csm_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_req_valid, a_req_ready, a_rsp_valid, a_err;
    logic [1:0] a_op, a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_req_valid, b_req_ready, b_rsp_valid, b_err;
    logic [1:0] b_op, b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    // Model: owner 0 = free, 1 = A, 2 = B; ptr 0 = A wins contention.
    logic [7:0] m_mem [4];
    int         m_own [4];
    int         m_ptr;
    int         m_errcnt;

    always #5 clk = ~clk;

    csm_arbiter #(.ADDR_W(2), .DATA_W(8), .ERRCNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op(a_op),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid),
        .a_rdata(a_rdata), .a_err(a_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op(b_op),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid),
        .b_rdata(b_rdata), .b_err(b_err),
        .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_apply(input int who, input logic [1:0] op, input logic [1:0] addr,
                                    input logic [7:0] wd, output bit err, output logic [7:0] rd);
        bit other;
        other = (m_own[addr] != 0) && (m_own[addr] != who);
        err = 0;
        rd  = 8'h00;
        case (op)
            2'd0: if (other) err = 1; else rd = m_mem[addr];
            2'd1: if (other) err = 1; else m_mem[addr] = wd;
            2'd2: if (other) err = 1; else if (m_own[addr] == 0) m_own[addr] = who;
            default: if (m_own[addr] == who) m_own[addr] = 0; else err = 1;
        endcase
        if (err && m_errcnt < 255) m_errcnt++;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        a_req_valid = 1'b1; a_op = 2'd0; a_addr = 2'd2; a_wdata = 8'h00;
        b_req_valid = 1'b1; b_op = 2'd0; b_addr = 2'd2; b_wdata = 8'h00;
        #1;
        chk("rst_a_ready", a_req_ready, 1'b0);
        chk("rst_b_ready", b_req_ready, 1'b0);
        @(posedge clk); #1;
        chk("rst_a_rsp_valid", a_rsp_valid, 1'b0);
        chk("rst_b_rsp_valid", b_rsp_valid, 1'b0);
        chk("rst_a_rdata", a_rdata, 8'h00);
        chk("rst_b_rdata", b_rdata, 8'h00);
        chk("rst_a_err", a_err, 1'b0);
        chk("rst_b_err", b_err, 1'b0);
        chk("rst_err_count", err_count, 8'h00);
        for (int i = 0; i < 4; i++) begin
            m_mem[i] = 8'h00;
            m_own[i] = 0;
        end
        m_ptr = 0;
        m_errcnt = 0;
        reset_n = 1'b1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    // One cycle: drive both ports, check grants, then check responses after the edge.
    task automatic step(input bit av, input logic [1:0] aop, input logic [1:0] aad, input logic [7:0] awd,
                        input bit bv, input logic [1:0] bop, input logic [1:0] bad, input logic [7:0] bwd,
                        output bit ga, output bit gb);
        bit ea, eb;
        logic [7:0] ra, rb;
        a_req_valid = av; a_op = aop; a_addr = aad; a_wdata = awd;
        b_req_valid = bv; b_op = bop; b_addr = bad; b_wdata = bwd;
        #1;
        ga = av && (!bv || m_ptr == 0);
        gb = bv && (!av || m_ptr == 1);
        if (av && bv) m_ptr = 1 - m_ptr;
        chk("a_req_ready", a_req_ready, ga);
        chk("b_req_ready", b_req_ready, gb);
        ea = 0; eb = 0; ra = 8'h00; rb = 8'h00;
        if (ga) m_apply(1, aop, aad, awd, ea, ra);
        if (gb) m_apply(2, bop, bad, bwd, eb, rb);
        @(posedge clk); #1;
        chk("a_rsp_valid", a_rsp_valid, ga);
        chk("b_rsp_valid", b_rsp_valid, gb);
        chk("a_rdata", a_rdata, ra);
        chk("b_rdata", b_rdata, rb);
        chk("a_err", a_err, ea);
        chk("b_err", b_err, eb);
        chk("err_count", err_count, m_errcnt[7:0]);
    endtask

    task automatic op_a(input logic [1:0] op, input logic [1:0] ad, input logic [7:0] wd);
        bit ga, gb;
        step(1, op, ad, wd, 0, 2'd0, 2'd0, 8'h00, ga, gb);
    endtask

    task automatic op_b(input logic [1:0] op, input logic [1:0] ad, input logic [7:0] wd);
        bit ga, gb;
        step(0, 2'd0, 2'd0, 8'h00, 1, op, ad, wd, ga, gb);
    endtask

    initial begin
        bit ga, gb, pa, pb;
        logic [1:0] rao, raa, rbo, rba;
        logic [7:0] raw, rbw;

        do_reset();

        // Plan 1: write then back-to-back read
        op_a(2'd1, 2'd2, 8'h5A);
        op_a(2'd0, 2'd2, 8'h00);
        chk("p1_read_5a", a_rdata, 8'h5A);

        // Plan 2: hold by A blocks B
        op_a(2'd1, 2'd1, 8'h3C);
        op_a(2'd2, 2'd1, 8'h00);
        op_b(2'd0, 2'd1, 8'h00);
        op_b(2'd1, 2'd1, 8'hFF);
        op_a(2'd0, 2'd1, 8'h00);
        chk("p2_orig_data", a_rdata, 8'h3C);
        chk("p2_err_count", err_count, 8'd2);

        // Plan 3: hold, release, foreign read, double hold
        op_a(2'd1, 2'd3, 8'h33);
        op_a(2'd2, 2'd3, 8'h00);
        op_a(2'd3, 2'd3, 8'h00);
        op_b(2'd0, 2'd3, 8'h00);
        op_a(2'd2, 2'd3, 8'h00);
        op_a(2'd2, 2'd3, 8'h00);
        op_a(2'd3, 2'd3, 8'h00);

        // Plan 4: continuous contention alternates A, B, A, B
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 2'd1, 2'd0, 8'(i), 1, 2'd0, 2'd0, 8'h00, ga, gb);
            chk("p4_alternate", {ga, gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // Plan 5: hold conflicts and double release
        do_reset();
        op_a(2'd2, 2'd0, 8'h00);
        op_b(2'd2, 2'd0, 8'h00);
        op_b(2'd3, 2'd0, 8'h00);
        op_a(2'd3, 2'd0, 8'h00);
        op_a(2'd3, 2'd0, 8'h00);
        chk("p5_err_count", err_count, 8'd3);

        // Plan 6: reset clears memory and ownership mid-stream
        for (int i = 0; i < 4; i++) op_a(2'd1, 2'(i), 8'(8'hA0 + i));
        op_b(2'd2, 2'd2, 8'h00);
        op_a(2'd0, 2'd2, 8'h00);
        a_req_valid = 1'b1; a_op = 2'd0; a_addr = 2'd3;
        do_reset();
        op_a(2'd0, 2'd2, 8'h00);
        chk("p6_cleared_data", a_rdata, 8'h00);
        chk("p6_err_count", err_count, 8'h00);

        // Counter saturation: B keeps hitting an A-held location
        op_a(2'd2, 2'd0, 8'h00);
        for (int i = 0; i < 260; i++) op_b(2'd0, 2'd0, 8'h00);
        chk("sat_err_count", err_count, 8'hFF);

        // Randomized traffic; an ungranted request is held stable until granted
        do_reset();
        pa = 0; pb = 0;
        rao = 0; raa = 0; raw = 0; rbo = 0; rba = 0; rbw = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pa) begin
                pa  = ($urandom_range(0, 3) != 0);
                rao = 2'($urandom_range(0, 3));
                raa = 2'($urandom_range(0, 3));
                raw = 8'($urandom);
            end
            if (!pb) begin
                pb  = ($urandom_range(0, 3) != 0);
                rbo = 2'($urandom_range(0, 3));
                rba = 2'($urandom_range(0, 3));
                rbw = 8'($urandom);
            end
            step(pa, rao, raa, raw, pb, rbo, rba, rbw, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end

        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
